// File: rtl/dff_mon.sv
// In-circuit checker for a muxed D flip-flop: predicts q, compares every cycle, counts results.
// Optional DFF_MON_HALT_EN: freeze checking in HALT on the first mismatch.
module dff_mon #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d0,
  input  logic             d1,
  input  logic             sel,
  input  logic             rst,
  input  logic             q,
  output logic             err_pulse,
  output logic             err_flag,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

`ifdef DFF_MON_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           st;
  logic             exp_q;
  logic [CNT_W-1:0] cyc_cnt;
  logic             pred;
  logic             mism;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Value the observed flop will load on this edge; compared one edge later.
  assign pred  = rst ? 1'b0 : (sel ? d1 : d0);
  assign mism  = (q != exp_q);
  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      exp_q         <= 1'b0;
      cyc_cnt       <= '0;
      err_pulse     <= 1'b0;
      err_flag      <= 1'b0;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      first_err_cyc <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (!en) begin
        st <= IDLE;
      end else begin
        case (st)
          IDLE: begin
            st      <= PRIME;
            cyc_cnt <= '0;
          end
          PRIME: begin
            exp_q <= pred;
            st    <= CHECK;
          end
          CHECK: begin
            exp_q   <= pred;
            cyc_cnt <= sat_inc(cyc_cnt);
            if (mism) begin
              err_cnt   <= sat_inc(err_cnt);
              err_pulse <= 1'b1;
              err_flag  <= 1'b1;
              if (!err_flag) first_err_cyc <= cyc_cnt;
              if (HALT_EN) st <= HALT;
            end else begin
              pass_cnt <= sat_inc(pass_cnt);
            end
          end
          HALT: st <= HALT;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
